// File: rtl/par_serial_gen.sv
// par_serial_gen: parallel-to-serial symbol generator with post-reset sync idles,
// one-entry holding register and gap-free idle insertion.
module par_serial_gen #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'('hBC),
    parameter int              SYNC_SYMS = 4,
    parameter bit              MSB_FIRST = 1'b1
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             frame_out,
    output logic             idle_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {INIT, SYNC, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg, hold, sym;
    logic             hold_full, boundary, xfer, load_idle;
    logic [3:0]       sync_cnt;

    assign ready_out = (state == ACTIVE) && !hold_full;
    assign xfer      = valid_in && ready_out;
    assign boundary  = (state == INIT) || (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_32f or negedge reset)
        if (!reset) state <= INIT;
        else        state <= state_nxt;

    // sync_cnt is 0 in INIT, so one comparison covers both INIT and SYNC exits
    always_comb begin
        state_nxt = state;
        if (boundary && state != ACTIVE)
            state_nxt = (sync_cnt + 4'd1 == 4'(SYNC_SYMS)) ? ACTIVE : SYNC;
        sym       = hold_full ? hold : xfer ? data_in : IDLE_SYM;
        load_idle = !hold_full && !xfer;
    end

    always_ff @(posedge clk_32f or negedge reset)
        if (!reset) begin
            cnt       <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            sync_cnt  <= '0;
            data_out  <= 1'b0;
            frame_out <= 1'b0;
            idle_out  <= 1'b0;
        end else if (boundary) begin
            cnt       <= '0;
            shreg     <= MSB_FIRST ? sym << 1 : sym >> 1;
            data_out  <= MSB_FIRST ? sym[WIDTH-1] : sym[0];
            frame_out <= 1'b1;
            idle_out  <= load_idle;
            hold_full <= 1'b0;
            if (state != ACTIVE) sync_cnt <= sync_cnt + 4'd1;
        end else begin
            cnt       <= cnt + 1'b1;
            shreg     <= MSB_FIRST ? shreg << 1 : shreg >> 1;
            data_out  <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            frame_out <= 1'b0;
            if (xfer) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end
        end
endmodule

// File: tb/tb_par_serial_gen.sv
// tb_par_serial_gen: scoreboard bench; the driver queues expected symbols and a
// negedge monitor reassembles serial symbols and compares them.
module tb_par_serial_gen;
    logic       clk_32f = 1'b0, reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_out, data_out, frame_out, idle_out;
    logic [9:0] data_in2 = '0;
    logic       valid_in2 = 1'b0;
    logic       ready2, data2, frame2, idle2;
    int         checks = 0, errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [7:0] msym;
    logic       midl;
    logic       mcol = 1'b0;
    int         mbit = 0;

    par_serial_gen dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .frame_out(frame_out), .idle_out(idle_out)
    );

    par_serial_gen #(.WIDTH(10), .IDLE_SYM(10'h17C), .SYNC_SYMS(1), .MSB_FIRST(1'b0)) dut2 (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in2), .valid_in(valid_in2),
        .ready_out(ready2), .data_out(data2), .frame_out(frame2), .idle_out(idle2)
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit expect_out);
        bit ok = 0;
        data_in  = d;
        valid_in = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk_32f);
            ok = ready_out;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk_32f);
        #1;
        if (expect_out) exp_q.push_back({d, 1'b0});
    endtask

    // Monitor: reassemble MSB-first symbols from data_out, aligned on frame_out
    always @(negedge clk_32f) begin
        if (!reset) begin
            mcol = 1'b0;
            mbit = 0;
        end else begin
            if (frame_out) begin
                if (mcol) chk("frame_spacing", mbit, 0);
                msym = {7'b0, data_out};
                midl = idle_out;
                mbit = 1;
                mcol = 1'b1;
            end else if (mcol) begin
                if (mbit == 0) chk("gap_free", frame_out, 1);
                else begin
                    msym = {msym[6:0], data_out};
                    mbit++;
                    chk("idle_const", idle_out, midl);
                end
            end
            if (mcol && mbit == 8) begin
                chk("sym_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("symbol", msym, e[8:1]);
                    chk("idle_flag", midl, e[0]);
                end
                mbit = 0;
            end
        end
    end

    initial begin
        logic [9:0] e2;
        e2 = 10'h17C;
        @(posedge reset);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_32f);
            chk("w10_bit", data2, e2[i % 10]);
            chk("w10_frame", frame2, i % 10 == 0);
            chk("w10_idle", idle2, 1);
        end
        chk("w10_ready", ready2, 1);
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk_32f);
        chk("rst_data", data_out, 0);
        chk("rst_frame", frame_out, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_idle", idle_out, 0);
        repeat (4) exp_q.push_back({8'hBC, 1'b1});
        #2 reset = 1'b1;
        repeat (10) @(negedge clk_32f);
        chk("sync_ready", ready_out, 0);
        send(8'hAA, 1);
        send(8'hBB, 1);
        send(8'hCC, 1);
        send(8'hDD, 1);
        valid_in = 1'b0;
        exp_q.push_back({8'hBC, 1'b1});
        repeat (16) @(posedge clk_32f);
        #1;
        send(8'hFF, 1);
        valid_in = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_32f);
            seen = frame_out;
        end
        chk("wait_frame", seen, 1);
        repeat (7) @(posedge clk_32f);
        #1;
        data_in  = 8'h5A;
        valid_in = 1'b1;
        @(posedge clk_32f);
        #1;
        valid_in = 1'b0;
        exp_q.push_back({8'h5A, 1'b0});
        chk("bypass_hold_empty", ready_out, 1);
        chk("bypass_loaded", frame_out, 1);
        repeat (2) @(posedge clk_32f);
        #1;
        data_in  = 8'h3C;
        valid_in = 1'b1;
        @(posedge clk_32f);
        #1;
        valid_in = 1'b0;
        exp_q.push_back({8'h3C, 1'b0});
        chk("hold_drops_ready", ready_out, 0);
        repeat (4) @(posedge clk_32f);
        #1;
        chk("hold_ready_low", ready_out, 0);
        @(posedge clk_32f);
        #1;
        chk("hold_release_ready", ready_out, 1);
        chk("hold_release_frame", frame_out, 1);
        send(8'hCC, 0);
        send(8'h99, 0);
        valid_in = 1'b0;
        chk("pre_reset_hold_full", ready_out, 0);
        repeat (2) @(posedge clk_32f);
        #1;
        chk("pre_reset_drain", exp_q.size(), 0);
        reset = 1'b0;
        #1;
        chk("async_data", data_out, 0);
        chk("async_frame", frame_out, 0);
        chk("async_ready", ready_out, 0);
        chk("async_idle", idle_out, 0);
        repeat (3) @(negedge clk_32f);
        chk("held_rst_data", data_out, 0);
        chk("held_rst_frame", frame_out, 0);
        repeat (5) exp_q.push_back({8'hBC, 1'b1});
        #2 reset = 1'b1;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk_32f);
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/par_serial_gen.md
PAR_SERIAL_GEN -- requirements
Module: par_serial_gen

Interface
Parameters:
REQ-001 The block SHALL provide parameter WIDTH, default 8: symbol width in bits; legal range 2..32.
REQ-002 The block SHALL provide parameter IDLE_SYM, default 8'hBC: the WIDTH-bit symbol sent when no data is available (the COM symbol at WIDTH=8).
REQ-003 The block SHALL provide parameter SYNC_SYMS, default 4: number of IDLE_SYM symbols sent after reset before data is accepted; legal range 1..15.
REQ-004 The block SHALL provide parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is serialised first, 0 = bit 0 first.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL provide clk_32f, input, 1: the single clock (the serial bit clock); all state changes on its rising edge.
REQ-006 The block SHALL provide reset, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL provide data_in, input, WIDTH: parallel symbol from upstream.
REQ-008 The block SHALL provide valid_in, input, 1: data_in is valid this cycle.
REQ-009 The block SHALL provide ready_out, output, 1: block can accept a symbol this cycle; transfer occurs when valid_in && ready_out at a rising edge.
REQ-010 The block SHALL provide data_out, output, 1: serial bit stream.
REQ-011 The block SHALL provide frame_out, output, 1: high while data_out carries the first bit of a symbol.
REQ-012 The block SHALL provide idle_out, output, 1: high while the symbol being serialised is an inserted IDLE_SYM.

Function
REQ-013 The block SHALL contain a WIDTH-bit shift register, a bit counter cnt (0..WIDTH-1, wrapping), a one-entry holding register with flag hold_full, a sync-symbol counter, and a state machine with states INIT, SYNC, ACTIVE.
REQ-014 A "boundary" SHALL be the rising edge in INIT, or any rising edge with cnt == WIDTH-1; a new symbol is loaded into the shift register only at a boundary, and cnt becomes 0 there.
REQ-015 data_out, frame_out and idle_out SHALL be registered; the bits of a symbol loaded at boundary edge E appear on data_out in the WIDTH cycles following E, in the order set by MSB_FIRST.
REQ-016 frame_out SHALL be 1 exactly in the first of those WIDTH cycles; idle_out SHALL be constant across all WIDTH cycles of the symbol.
REQ-017 INIT: on the first edge after reset release, the block SHALL load IDLE_SYM and go to SYNC, with the sync count at 1.
REQ-018 SYNC: at each boundary the block SHALL load IDLE_SYM and increment the sync count; at the boundary that loads symbol number SYNC_SYMS it SHALL go to ACTIVE; with SYNC_SYMS=1 the block goes INIT -> ACTIVE directly.
REQ-019 ready_out SHALL equal (state == ACTIVE) && !hold_full and SHALL be driven combinationally from flops.
REQ-020 At an ACTIVE non-boundary edge, a transfer SHALL write data_in into the holding register and set hold_full.
REQ-021 At an ACTIVE boundary, the load source SHALL be chosen in this order:
- hold_full: load the holding register, clear hold_full, idle_out = 0.
- else if a transfer occurs: load data_in directly (bypass), hold_full stays 0, idle_out = 0.
- else: load IDLE_SYM, idle_out = 1.
REQ-022 At a boundary where hold_full = 1 and ready_out is therefore 0, valid_in SHALL be ignored; upstream holds its data.
REQ-023 The stream SHALL be gap-free: exactly one bit per clock from the first post-reset load onward, with no stall cycles.
REQ-024 Upstream holding valid_in high continuously SHALL achieve one symbol per WIDTH cycles with no IDLE_SYM inserted after sync.

Reset
REQ-025 While reset = 0, the block SHALL be in INIT, with data_out, frame_out, ready_out = 0, idle_out = 0, shift register = 0, cnt = 0, hold_full = 0 and sync count = 0, all asynchronously.
REQ-026 Assertion of reset mid-symbol SHALL abort that symbol and discard any held symbol immediately; after release the full SYNC sequence SHALL repeat.

Verification
REQ-027 Reset: with reset = 0 and clk_32f toggling, data_out, frame_out, ready_out and idle_out SHALL all read 0; after release, data_out shall begin 10111100 repeated 4 times, with frame_out pulsing every 8 cycles and idle_out = 1.
REQ-028 Back-to-back data: valid_in held at 1 with data_in AA, BB, CC, DD, each advanced on transfer, SHALL give 10101010 10111011 11001100 11011101 immediately after the 4th sync symbol, with idle_out = 0 and no gaps.
REQ-029 Idle insertion: valid_in = 0 for one symbol period between DD and FF SHALL produce the sequence DD, BC (idle_out = 1), FF.
REQ-030 Bypass vs hold: a transfer exactly at a boundary with the hold empty SHALL be serialised next, with hold_full staying 0; a transfer mid-symbol SHALL set hold_full and drop ready_out until the next boundary.
REQ-031 Parameters: with WIDTH = 10, IDLE_SYM = 10'h17C, MSB_FIRST = 0 and SYNC_SYMS = 1, the output SHALL begin 0011111010 LSB first, with frame_out every 10 cycles.
REQ-032 Reset mid-operation: reset = 0 asserted at bit 3 of symbol CC with hold_full = 1 SHALL zero all outputs at once; after release the bench SHALL see the SYNC sequence again and no CC or held data.
